crc_fcs_check: RTL
==================

// Module: crc_fcs_check
// PURPOSE
//  Downstream of the segmented CRC engine (CRC-xor + go-back pipeline). Queues the received FCS word
//  of each frame, captured by the framing stage at EOP, and pairs it in order with the next computed
//  CRC result from the engine. Emits a per-frame pass/fail verdict and error pulses. Optional frame
//  statistics counters are provided. Received FCS always leads the computed CRC, which is delayed by
//  the engine pipeline, so a FIFO absorbs the skew.
// PARAMETERS
//  FCS_DEPTH  16  FCS FIFO entries; power of two, >=2; sets max frames in flight inside the engine
//  CNT_WIDTH  32  width of statistics counters (CRC_STATS_EN only)
// PORTS
//  clk          in   1          single clock
//  rst          in   1          reset, synchronous, active-low
//  fcs_valid    in   1          push fcs_in (one pulse per frame)
//  fcs_in       in   32         received FCS, already in engine bit order
//  fcs_full     out  1          FIFO full; upstream must not push
//  crc_en_in    in   1          computed CRC valid (engine crc_en_out)
//  crc_in       in   32         computed CRC (engine crc_out)
//  chk_valid    out  1          verdict strobe, 1 cycle
//  chk_pass     out  1          1 = crc_in matched the FCS at the FIFO head
//  chk_crc      out  32         computed CRC of the judged frame
//  chk_fcs      out  32         received FCS of the judged frame
//  orphan_err   out  1          1-cycle pulse: CRC arrived while FIFO empty
//  ovf_err      out  1          1-cycle pulse: push attempted while full
//  good_cnt     out  CNT_WIDTH  frames passed (CRC_STATS_EN)
//  bad_cnt      out  CNT_WIDTH  frames failed (CRC_STATS_EN)
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): wr/rd pointers=0, FIFO empty, fcs_full=0, chk_valid=0, chk_pass=0,
//    chk_crc=0, chk_fcs=0, orphan_err=0, ovf_err=0, counters=0. FIFO contents are not cleared.
//    Reset mid-frame discards all queued FCS words; the next crc_en_in after reset is orphan.
//  - FIFO: pointers are log2(FCS_DEPTH)+1 bits with wrap bit; empty = ptrs equal; full = low bits
//    equal and wrap bits differ. fcs_full is combinational from the registered pointers.
//  - Push = fcs_valid & ~full. Pop = crc_en_in & ~empty. Push and pop in the same cycle are both
//    honoured. When full, the pop frees no slot for that cycle's push: the push is dropped and
//    ovf_err pulses. When empty, there is no bypass: the CRC is orphaned even if fcs_valid is high.
//  - Verdict is registered. Latency is 1 cycle: crc_en_in at cycle N gives chk_valid at N+1, with
//    chk_pass = (crc_in == head), chk_crc = crc_in, chk_fcs = head.
//  - Orphan: crc_en_in & empty gives orphan_err=1 at N+1 and chk_valid=0. No pop, no counter change.
//  - ovf_err at N+1 for a dropped push at N; FIFO state is unchanged by the dropped push.
//  - chk_crc/chk_fcs/chk_pass hold their last values while chk_valid=0.
//  - Back-to-back crc_en_in every cycle is supported (one verdict per cycle).
// CONFIGURATION
//  CRC_STATS_EN defined: good_cnt increments on chk_valid&chk_pass, bad_cnt on chk_valid&~chk_pass.
//    Both update in the same cycle as chk_valid is asserted. They saturate at all-ones and never wrap.
//  CRC_STATS_EN undefined: no counter registers; good_cnt and bad_cnt are tied to 0. All other
//    behaviour is identical.
// TESTING
//  1. Push fcs 0xCBF43926, then crc_en_in with crc 0xCBF43926 -> chk_valid 1 cycle later, chk_pass=1,
//     chk_fcs=0xCBF43926, good_cnt=1.
//  2. Push 0x11111111, 0x22222222, 0x33333333; CRCs 0x11111111, 0xDEADBEEF, 0x33333333 on consecutive
//     cycles -> verdicts pass, fail, pass on 3 consecutive cycles; bad_cnt=1, good_cnt=2.
//  3. Push 16 words (FCS_DEPTH=16) -> fcs_full=1. 17th push -> ovf_err pulse. Push+pop while full ->
//     push dropped with ovf_err, occupancy 15. Drain 15 -> in-order values, last entry = 16th word.
//  4. crc_en_in with FIFO empty (with and without fcs_valid same cycle) -> orphan_err=1, chk_valid=0,
//     counters unchanged. In the fcs_valid case the word is queued and the next CRC pairs with it.
//  5. Push 3 words, assert rst low 1 cycle, then crc_en_in -> orphan_err, fcs_full=0, counters=0.
//  6. Force good_cnt to all-ones (CNT_WIDTH=4 build, 16 passes) -> stays 0xF. Build without
//     CRC_STATS_EN -> counters 0 throughout.

Source files
------------

// File: rtl/crc_fcs_check.sv
// ---------------------------------------------------------------------------
// crc_fcs_check
//   Pairs each received FCS word with the next computed CRC from the
//   segmented CRC engine. It then issues a registered pass/fail verdict one
//   cycle after the CRC arrives.
//
//   The received FCS always arrives ahead of the computed CRC, because the
//   engine pipeline delays the CRC. A small FIFO absorbs that skew. Its
//   pointers carry one extra wrap bit, so empty and full can be told apart
//   without an occupancy counter.
//
//   Optional feature macro: CRC_STATS_EN
//     defined   -> saturating good/bad frame counters
//     undefined -> good_cnt/bad_cnt tied to zero, no counter registers
// ---------------------------------------------------------------------------
module crc_fcs_check #(
    parameter int FCS_DEPTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fcs_valid,
    input  logic [31:0]          fcs_in,
    output logic                 fcs_full,
    input  logic                 crc_en_in,
    input  logic [31:0]          crc_in,
    output logic                 chk_valid,
    output logic                 chk_pass,
    output logic [31:0]          chk_crc,
    output logic [31:0]          chk_fcs,
    output logic                 orphan_err,
    output logic                 ovf_err,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    localparam int          AW      = $clog2(FCS_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // FCS storage and wrap-bit pointers
    logic [31:0] fcs_mem [FCS_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [31:0] head;
    logic        match;

    // Occupancy flags come straight from the registered pointers.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                        (wr_ptr[AW] != rd_ptr[AW]);
    assign fcs_full   = fifo_full;

    // While the FIFO is full, a same-cycle pop does not open a slot for the
    // push. While it is empty, an incoming FCS is not bypassed to the CRC.
    assign push  = fcs_valid & ~fifo_full;
    assign pop   = crc_en_in & ~fifo_empty;

    assign head  = fcs_mem[rd_ptr[AW-1:0]];
    assign match = (crc_in == head);

    // Write the received FCS into the slot at the write pointer.
    // NOTE: the storage array is deliberately left out of reset. The pointers
    // alone define which entries are valid, and an unreset array maps onto
    // plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            fcs_mem[wr_ptr[AW-1:0]] <= fcs_in;
        end
    end

    // Advance the pointers. Reset empties the FIFO and discards queued words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Register the verdict and the error strobes. The verdict data holds
    // while no verdict is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            chk_crc    <= '0;
            chk_fcs    <= '0;
            orphan_err <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            chk_valid  <= pop;
            orphan_err <= crc_en_in & fifo_empty;
            ovf_err    <= fcs_valid & fifo_full;
            if (pop) begin
                chk_pass <= match;
                chk_crc  <= crc_in;
                chk_fcs  <= head;
            end
        end
    end

`ifdef CRC_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] good_q;
    logic [CNT_WIDTH-1:0] bad_q;

    // Count judged frames. The counters saturate at all-ones and update on
    // the same edge that raises chk_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (pop) begin
            if (match) begin
                if (good_q != '1) good_q <= good_q + CNT_ONE;
            end else begin
                if (bad_q != '1) bad_q <= bad_q + CNT_ONE;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule
